i2c_slave: RTL
==============

# i2c_slave

Byte-oriented I2C target (slave) that sits on the same two-wire bus as the I2C master peripheral and answers it. It oversamples SCL/SDA on the system clock, detects START/STOP/repeated START, matches a fixed 7-bit address, ACKs and delivers written bytes, and serves read bytes through a request/data handshake. It is used as an on-chip bus partner and as the bus-level target for verifying the master.

## Interface
- `SLV_ADDR`, 7'h50, 7-bit address this target responds to.
- `clk_i`  in  1  system clock; all logic is in this domain.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `scl_i`  in  1  bus SCL, asynchronous to `clk_i`; SCL is input only, with no clock stretching.
- `sda_i`  in  1  bus SDA level, asynchronous to `clk_i`.
- `sda_oe_o`  out  1  1 = pull SDA low; 0 = release. SDA is open-drain, and the pad ties it to 0 when enabled.
- `rx_data_o`  out  8  last byte written by the master.
- `rx_valid_o`  out  1  1-cycle pulse; `rx_data_o` is valid this cycle.
- `tx_req_o`  out  1  1-cycle pulse; the next read byte is needed on `tx_data_i`.
- `tx_data_i`  in  8  read byte; sampled as specified under Timing.
- `busy_o`  out  1  1 from address match until STOP or until a non-matching transaction.
- `start_o`  out  1  1-cycle pulse on each START or repeated START.
- `stop_o`  out  1  1-cycle pulse on each STOP.

## Operation
- **Synchronisation and edge detection**
  - `scl_i` and `sda_i` each pass through a 2-flop synchroniser plus one history flop.
  - Edges are detected on the synchronised values (`scl_s`, `sda_s`).
- **Bus conditions**
  - START: `sda_s` falls while `scl_s` is 1.
  - STOP: `sda_s` rises while `scl_s` is 1.
  - Both are recognised in every state and override all other activity.
- **Bit transfer**
  - Bits are MSB first.
  - The target samples SDA on the SCL rising edge.
  - The target changes `sda_oe_o` only in the cycle after an SCL falling edge.
- **Bit counter:** 3 bits, loaded with 7, decremented per sampled bit. The byte is complete when bit 0 is sampled.
- **FSM states:** IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK.
  - **IDLE:** START → ADDR. All other bus activity is ignored.
  - **ADDR:** shift 8 bits.
    - If byte[7:1] == `SLV_ADDR`: set `busy_o`, latch R/W = byte[0], go to ADDR_ACK.
    - Otherwise: go to IDLE with `sda_oe_o` = 0.
  - **ADDR_ACK:**
    - Drive `sda_oe_o` = 1 for the ninth clock.
    - If R/W = 1, pulse `tx_req_o` at the ninth SCL rising edge.
    - On the ninth SCL falling edge → RD if R/W = 1, else WR.
  - **WR:**
    - Shift 8 bits.
    - After bit 0, update `rx_data_o` and pulse `rx_valid_o` one cycle after the sampling cycle.
    - Go to WR_ACK.
  - **WR_ACK:** drive ACK for the ninth clock, then → WR. Every written byte is ACKed.
  - **RD:**
    - On entry, load the shift register from `tx_data_i`.
    - Present each bit: `sda_oe_o` = ~bit.
    - After 8 bits → RD_ACK, with `sda_oe_o` released.
  - **RD_ACK:** sample the master's ACK at the ninth SCL rising edge.
    - SDA = 0 (ACK): pulse `tx_req_o`; → RD on the ninth falling edge.
    - SDA = 1 (NACK): → IDLE and release SDA. The master then issues STOP.
- **START/STOP override**
  - STOP from any state: → IDLE, `sda_oe_o` = 0, `busy_o` = 0, pulse `stop_o`.
  - Repeated START from any state: → ADDR, `busy_o` = 0, pulse `start_o`.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; bit counter 7; shift register 0.
- **Clock ratio:** correct operation requires `clk_i` ≥ 16 × the SCL frequency.
- **Detection latency:**
  - A bus edge is acted on 3 `clk_i` cycles after it occurs on the pin (2 synchroniser stages plus edge detect).
  - `start_o` / `stop_o` pulse in that third cycle.
- **`rx_valid_o`:** 1 cycle after the bit-0 sampling cycle.
- **`tx_data_i` handshake**
  - `tx_req_o` pulses at the ninth SCL rising edge.
  - `tx_data_i` is sampled on the following SCL falling edge, i.e. it must be stable within half an SCL period.
  - Data is not re-sampled within a byte.
- **SDA drive:** `sda_oe_o` changes at most once per SCL low phase and never while SCL is high, except for release on STOP/START/reset.
- **Reset mid-transfer:** asserting `rst_ni` releases SDA immediately (asynchronously). After release, the block waits for the next START.

## Test plan
- **Write 2 bytes:** START, 0xA0, 0x12, 0x34, STOP → ACK on all three bytes; `rx_valid_o` twice with 0x12 then 0x34; `start_o` ×1, `stop_o` ×1; `busy_o` 1 during the transfer, 0 after STOP.
- **Wrong address:** START, 0x42 (write), 0x55 → `sda_oe_o` stays 0 for the whole transfer; no `rx_valid_o`; `busy_o` stays 0.
- **Read 3 bytes:** START, 0xA1; `tx_data_i` = 0xC3, then 0x5A, then 0xFF per `tx_req_o`; master ACK, ACK, NACK, then STOP → SDA bytes observed are C3, 5A, FF; `tx_req_o` pulses exactly 3 times; FSM returns to IDLE.
- **Repeated START:** write 0xA0, 0x07, then Sr, 0xA1, read 1 byte with NACK → `rx_data_o` = 0x07; `start_o` ×2; read byte matches `tx_data_i`.
- **Abort:** STOP injected after 4 bits of a data byte, and separately `rst_ni` pulsed low during ADDR_ACK → SDA released within 3 cycles (STOP case) or immediately (reset case); IDLE; no `rx_valid_o`.
- **Back-to-back against the I2C master:** address 0x50, 4-byte write 0xDEADBEEF → `rx_data_o` sequence DE, AD, BE, EF.

Source files
------------

// File: rtl/i2c_slave.sv
// ============================================================================
// i2c_slave : oversampled byte-oriented I2C target, fixed 7-bit address
// Rev 1.0   : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       tx_req_o,
    input  logic [7:0] tx_data_i,
    output logic       busy_o,
    output logic       start_o,
    output logic       stop_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR       = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD       = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_e;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       rw_q, rw_d;
    logic       ph_q, ph_d;
    logic       busy_q, busy_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    // Synchronisers reset to the idle (high) bus level so reset release is not seen as an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  =  scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s &  scl_hist_q;
    assign start_det =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 3'd7;
            shreg_q    <= 8'h00;
            rw_q       <= 1'b0;
            ph_q       <= 1'b0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            ph_q       <= ph_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // ph_q marks the second half of a byte slot: in the ACK states it is set by the
    // ninth SCL rise, in RD by the rise that shifted out bit 0.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        ph_d       = ph_q;
        busy_d     = busy_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;

        if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else if (start_det) begin
            state_d  = ST_ADDR;
            oe_d     = 1'b0;
            busy_d   = 1'b0;
            start_d  = 1'b1;
            bitcnt_d = 3'd7;
            ph_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        if (bitcnt_q == 3'd0) begin
                            bitcnt_d = 3'd7;
                            if (shreg_q[6:0] == SLV_ADDR) begin
                                busy_d  = 1'b1;
                                rw_d    = sda_s;
                                ph_d    = 1'b0;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                oe_d    = 1'b0;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end

                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_rise) begin
                        ph_d = 1'b1;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            tx_req_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (!ph_q) begin
                            oe_d = 1'b1;
                        end else if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d  = ST_RD;
                            shreg_d  = tx_data_i;
                            oe_d     = ~tx_data_i[7];
                            bitcnt_d = 3'd7;
                            ph_d     = 1'b0;
                        end else begin
                            state_d  = ST_WR;
                            oe_d     = 1'b0;
                            bitcnt_d = 3'd7;
                        end
                    end
                end

                ST_WR: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        if (bitcnt_q == 3'd0) begin
                            rx_data_d  = {shreg_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            bitcnt_d   = 3'd7;
                            ph_d       = 1'b0;
                            state_d    = ST_WR_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end

                ST_RD: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        if (bitcnt_q == 3'd0) begin
                            ph_d     = 1'b1;
                            bitcnt_d = 3'd7;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end else if (scl_fall) begin
                        if (ph_q) begin
                            state_d = ST_RD_ACK;
                            oe_d    = 1'b0;
                            ph_d    = 1'b0;
                        end else begin
                            oe_d = ~shreg_q[7];
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ph_d     = 1'b1;
                            tx_req_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            oe_d    = 1'b0;
                        end
                    end else if (scl_fall && ph_q) begin
                        state_d  = ST_RD;
                        shreg_d  = tx_data_i;
                        oe_d     = ~tx_data_i[7];
                        bitcnt_d = 3'd7;
                        ph_d     = 1'b0;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign sda_oe_o   = oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_req_o   = tx_req_q;
    assign busy_o     = busy_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

`default_nettype wire
